// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX payload, waits for the data-SRAM response of an
// issued load/store, extends load data and hands results and exceptions to WB.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic        es_res_from_mem,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic        es_mem_req,
    input  logic [4:0]  es_ld_op,
    input  logic [6:0]  es_except,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        except_flush,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [6:0]  ms_except,
    output logic [38:0] ms_rf_collect,
    output logic        ms_ex
);

    localparam int LD_W  = 4;
    localparam int LD_H  = 3;
    localparam int LD_HU = 2;
    localparam int LD_B  = 1;
    localparam int LD_BU = 0;

    logic        ms_valid_reg;
    logic [31:0] ms_pc_reg;
    logic [31:0] ms_result_reg;
    logic        ms_res_from_mem_reg;
    logic        ms_rf_we_reg;
    logic [4:0]  ms_rf_waddr_reg;
    logic        ms_mem_req_reg;
    logic [4:0]  ms_ld_op_reg;
    logic [6:0]  ms_except_reg;
    logic [31:0] data_buf_reg;
    logic        data_buf_valid_reg;
    logic        discard_reg;

    logic        resp_hit;
    logic        ms_ready_go;
    logic        handoff;
    logic        capture;

    // A response that belongs to a flushed instruction is never a hit.
    assign resp_hit       = data_sram_data_ok & ~discard_reg;
    assign ms_ready_go    = ~ms_mem_req_reg | data_buf_valid_reg | resp_hit;
    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go;
    assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ws_allowin);
    assign handoff        = ms_to_ws_valid & ws_allowin;
    assign capture        = es_to_ms_valid & ms_allowin & ~except_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_reg <= 1'b0;
        end else if (except_flush) begin
            ms_valid_reg <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_reg <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_pc_reg           <= 32'd0;
            ms_result_reg       <= 32'd0;
            ms_res_from_mem_reg <= 1'b0;
            ms_rf_we_reg        <= 1'b0;
            ms_rf_waddr_reg     <= 5'd0;
            ms_mem_req_reg      <= 1'b0;
            ms_ld_op_reg        <= 5'd0;
            ms_except_reg       <= 7'd0;
        end else if (capture) begin
            ms_pc_reg           <= es_pc;
            ms_result_reg       <= es_result;
            ms_res_from_mem_reg <= es_res_from_mem;
            ms_rf_we_reg        <= es_rf_we;
            ms_rf_waddr_reg     <= es_rf_waddr;
            ms_mem_req_reg      <= es_mem_req;
            ms_ld_op_reg        <= es_ld_op;
            ms_except_reg       <= es_except;
        end
    end

    // Holds the returned word while WB back-pressures, since rdata is only valid with data_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf_reg       <= 32'd0;
            data_buf_valid_reg <= 1'b0;
        end else if (except_flush || handoff) begin
            data_buf_valid_reg <= 1'b0;
        end else if (resp_hit && ms_valid_reg && ms_mem_req_reg && !ws_allowin && !data_buf_valid_reg) begin
            data_buf_reg       <= data_sram_rdata;
            data_buf_valid_reg <= 1'b1;
        end
    end

    // At most one request is outstanding, so one flag is enough to drop a stale beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_reg <= 1'b0;
        end else if (data_sram_data_ok) begin
            discard_reg <= 1'b0;
        end else if (except_flush && ms_valid_reg && ms_mem_req_reg && !data_buf_valid_reg) begin
            discard_reg <= 1'b1;
        end
    end

    logic [31:0] load_word;
    logic [7:0]  lane_byte [4];
    logic [15:0] lane_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    assign load_word = data_buf_valid_reg ? data_buf_reg : data_sram_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign lane_byte[gi] = load_word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign lane_half[gi] = load_word[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        sel_byte = lane_byte[ms_result_reg[1:0]];
        sel_half = lane_half[ms_result_reg[1]];
        load_ext = load_word;
        if (ms_ld_op_reg[LD_H]) begin
            load_ext = {{16{sel_half[15]}}, sel_half};
        end else if (ms_ld_op_reg[LD_HU]) begin
            load_ext = {16'd0, sel_half};
        end else if (ms_ld_op_reg[LD_B]) begin
            load_ext = {{24{sel_byte[7]}}, sel_byte};
        end else if (ms_ld_op_reg[LD_BU]) begin
            load_ext = {24'd0, sel_byte};
        end else if (ms_ld_op_reg[LD_W]) begin
            load_ext = load_word;
        end
    end

    assign ms_final_result = ms_res_from_mem_reg ? load_ext : ms_result_reg;
    assign ms_pc           = ms_pc_reg;
    assign ms_rf_we        = ms_rf_we_reg & ms_valid_reg;
    assign ms_rf_waddr     = ms_rf_waddr_reg;
    assign ms_except       = ms_except_reg & {7{ms_valid_reg}};
    assign ms_ex           = (|ms_except_reg) & ms_valid_reg;
    assign ms_rf_collect   = {ms_res_from_mem_reg & ms_valid_reg & ~ms_ready_go,
                              ms_rf_we, ms_rf_waddr, ms_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: the bench plays EX, the data SRAM and WB, and a
// scoreboard of expected WB handoffs is checked by an independent monitor.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic        es_res_from_mem;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_mem_req;
    logic [4:0]  es_ld_op;
    logic [6:0]  es_except;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        except_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [6:0]  ms_except;
    logic [38:0] ms_rf_collect;
    logic        ms_ex;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_res_from_mem   (es_res_from_mem),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_mem_req        (es_mem_req),
        .es_ld_op          (es_ld_op),
        .es_except         (es_except),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .except_flush      (except_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_except         (ms_except),
        .ms_rf_collect     (ms_rf_collect),
        .ms_ex             (ms_ex)
    );

    localparam int K_ALU = 0, K_ST = 1, K_LDW = 2, K_LDH = 3, K_LDHU = 4,
                   K_LDB = 5, K_LDBU = 6, K_EXC = 7;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [6:0]  exc;
        bit          mem_req;
        bit          is_load;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    exp_t  sb[$];
    resp_t resp_q[$];
    bit    head_got;
    int    stale_cnt;
    int    cyc;
    int    last_due;
    exp_t  offer_exp;
    logic [31:0] offer_rdata;
    int    total = 0;
    int    bad = 0;
    bit    mon_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load result straight from the architectural rules: pick the lane, then extend.
    function automatic logic [31:0] ref_load(input int kind, input logic [31:0] addr, input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * addr[1:0])) & 32'hff;
        h = (w >> (16 * addr[1])) & 32'hffff;
        case (kind)
            K_LDB:   return (b >= 128) ? b - 32'd256 : b;
            K_LDBU:  return b;
            K_LDH:   return (h >= 32768) ? h - 32'd65536 : h;
            K_LDHU:  return h;
            default: return w;
        endcase
    endfunction

    task automatic new_offer();
        int kind;
        logic [31:0] addr;
        logic [31:0] w;
        kind = $urandom_range(0, 7);
        addr = $urandom;
        w    = $urandom;
        if ($urandom_range(0, 1) == 1) w[8*$urandom_range(0, 3) +: 8] = 8'h80 | 8'($urandom_range(0, 127));
        if (kind == K_LDW) addr[1:0] = 2'b00;
        if (kind == K_LDH || kind == K_LDHU) addr[0] = 1'b0;
        es_pc           = $urandom;
        es_result       = addr;
        es_rf_waddr     = 5'($urandom);
        es_res_from_mem = (kind >= K_LDW && kind <= K_LDBU);
        es_mem_req      = (kind >= K_ST && kind <= K_LDBU);
        es_rf_we        = es_res_from_mem ? 1'b1 : (kind == K_ST) ? 1'b0 : 1'($urandom);
        es_except       = (kind == K_EXC) ? 7'($urandom_range(1, 127)) : 7'd0;
        case (kind)
            K_LDW:   es_ld_op = 5'b10000;
            K_LDH:   es_ld_op = 5'b01000;
            K_LDHU:  es_ld_op = 5'b00100;
            K_LDB:   es_ld_op = 5'b00010;
            K_LDBU:  es_ld_op = 5'b00001;
            default: es_ld_op = 5'b00000;
        endcase
        offer_rdata = w;
        offer_exp   = '{pc: es_pc,
                        result: es_res_from_mem ? ref_load(kind, addr, w) : addr,
                        rf_we: es_rf_we, waddr: es_rf_waddr, exc: es_except,
                        mem_req: es_mem_req, is_load: es_res_from_mem};
        es_to_ms_valid = 1'b1;
    endtask

    // One clock of EX/SRAM/WB activity, entered and left at posedge+1.
    task automatic drive_cycle(input bit active);
        bit ok;
        bit fl;
        bit acc;
        if (active && $urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            es_to_ms_valid = 1'b0;
            except_flush = 1'b0;
            data_sram_data_ok = 1'b0;
            sb.delete();
            resp_q.delete();
            head_got = 0;
            stale_cnt = 0;
            @(posedge clk);
            #1;
            cyc++;
            last_due = cyc;
            reset = 1'b0;
            return;
        end
        ok = (resp_q.size() > 0) && (resp_q[0].due <= cyc);
        fl = active && (resp_q.size() <= 1) && ($urandom_range(0, 19) == 0);
        data_sram_data_ok = ok;
        data_sram_rdata   = ok ? resp_q[0].data : $urandom;
        except_flush      = fl;
        ws_allowin        = active ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (!es_to_ms_valid && active && $urandom_range(0, 9) < 7) new_offer();
        @(negedge clk);
        acc = es_to_ms_valid && ms_allowin && !except_flush;
        @(posedge clk);
        #1;
        cyc++;
        if (ok) begin
            if (stale_cnt > 0) stale_cnt--;
            else if (sb.size() > 0) head_got = 1;
            void'(resp_q.pop_front());
        end
        if (fl) begin
            sb.delete();
            head_got = 0;
            stale_cnt = resp_q.size();
        end
        if (acc) begin
            if (sb.size() == 0) head_got = 0;
            sb.push_back(offer_exp);
            if (offer_exp.mem_req) begin
                int due;
                due = $urandom_range(0, 3) + cyc;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                resp_q.push_back('{data: offer_rdata, due: due});
            end
            es_to_ms_valid = 1'b0;
        end else if (fl) begin
            es_to_ms_valid = 1'b0;
        end
    endtask

    // Monitor: per-cycle control check plus payload check on every WB handoff.
    exp_t h;
    bit   m_v;
    bit   m_rdy;
    logic [3:0] m_exp_ctl;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            m_v = (sb.size() > 0);
            h = m_v ? sb[0] : '{default: 0};
            m_rdy = !h.mem_req || head_got || (data_sram_data_ok && stale_cnt == 0);
            m_exp_ctl = {m_v && m_rdy, !m_v || (m_rdy && ws_allowin),
                         m_v && (h.exc != 7'd0), m_v && h.is_load && !m_rdy};
            chk("ctl{to_ws,allowin,ex,stall}",
                128'({ms_to_ws_valid, ms_allowin, ms_ex, ms_rf_collect[38]}), 128'(m_exp_ctl));
            if (m_v && m_rdy && ws_allowin && !except_flush) begin
                $display("handoff pc=%h result=%h (expected %h) rf_we=%0d waddr=%0d exc=%b",
                         ms_pc, ms_final_result, h.result, ms_rf_we, ms_rf_waddr, ms_except);
                chk("handoff{pc,result,we,waddr,exc,collect}",
                    128'({ms_pc, ms_final_result, ms_rf_we, ms_rf_waddr, ms_except, ms_rf_collect[37:0]}),
                    128'({h.pc, h.result, h.rf_we, h.waddr, h.exc, h.rf_we, h.waddr, h.result}));
                void'(sb.pop_front());
                head_got = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_pc = '0;
        es_result = '0;
        es_res_from_mem = 1'b0;
        es_rf_we = 1'b0;
        es_rf_waddr = '0;
        es_mem_req = 1'b0;
        es_ld_op = '0;
        es_except = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        except_flush = 1'b0;
        ws_allowin = 1'b1;
        head_got = 0;
        stale_cnt = 0;
        cyc = 0;
        last_due = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ms_allowin", 128'(ms_allowin), 128'(1));
        chk("reset ms_to_ws_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("reset ms_pc", 128'(ms_pc), 128'(0));
        chk("reset ms_final_result", 128'(ms_final_result), 128'(0));
        chk("reset ms_rf_collect", 128'(ms_rf_collect), 128'(0));
        chk("reset ms_ex", 128'(ms_ex), 128'(0));
        chk("reset ms_rf_we", 128'(ms_rf_we), 128'(0));
        chk("reset ms_except", 128'(ms_except), 128'(0));
        chk("reset ms_rf_waddr", 128'(ms_rf_waddr), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1;

        for (int i = 0; i < 4000; i++) drive_cycle(1'b1);

        // Drain: no new work, WB always ready, every queued response delivered.
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && resp_q.size() == 0 && !es_to_ms_valid) break;
            drive_cycle(1'b0);
        end
        chk("drain {sb,resp,offer}",
            128'({16'(sb.size()), 16'(resp_q.size()), es_to_ms_valid}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, sitting directly downstream of the EX stage and upstream of WB.
- Latches the EX→MEM payload and waits for the data-SRAM response of any load/store that EX already issued (address handshake done).
- Extends load data by type and forwards results and exceptions to WB.
- Publishes a forwarding/hazard bundle for ID and an exception summary that EX uses to suppress stores.
- Tracks cancelled in-flight requests across an exception flush.

Parameters:
- none (datapath fixed at 32 bits).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- es_to_ms_valid  in  1  EX has a valid instruction for MEM.
- ms_allowin  out  1  MEM can accept this cycle.
- es_pc  in  32  PC of the EX instruction.
- es_result  in  32  ALU/mul/div/csr/counter result, or the memory byte address for loads/stores.
- es_res_from_mem  in  1  instruction is a load.
- es_rf_we  in  1  register-file write enable.
- es_rf_waddr  in  5  destination register.
- es_mem_req  in  1  EX issued a data-SRAM request (address accepted).
- es_ld_op  in  5  one-hot {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
- es_except  in  7  {ale, adef, ine, syscall, break, int, ertn} collected so far.
- data_sram_data_ok  in  1  response beat for the oldest outstanding request.
- data_sram_rdata  in  32  read data, valid with data_ok.
- except_flush  in  1  WB exception/ertn flush.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  MEM hands an instruction to WB.
- ms_pc  out  32  registered PC.
- ms_final_result  out  32  extended load data or passed-through result.
- ms_rf_we  out  1  gated by ms_valid.
- ms_rf_waddr  out  5  destination register.
- ms_except  out  7  es_except latched, gated by ms_valid.
- ms_rf_collect  out  39  {ms_res_from_mem & ms_valid & ~ms_ready_go, ms_rf_we, ms_rf_waddr, ms_final_result} for ID forwarding/stall.
- ms_ex  out  1  |ms_except & ms_valid; EX blocks store strobes when high.

Behaviour:
- Reset values: all payload registers, ms_valid, data_buf_valid and discard set to 0.
  - Outputs at reset: ms_allowin=1, ms_to_ws_valid=0, all other outputs 0.
- Valid register: on except_flush, ms_valid←0; otherwise, when ms_allowin, ms_valid←es_to_ms_valid.
- Payload capture: payload registers load when es_to_ms_valid & ms_allowin & ~except_flush.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- resp_hit = data_sram_data_ok & ~discard.
- ms_ready_go = ~ms_mem_req | data_buf_valid | resp_hit.
  - Zero added latency: a response in the same cycle completes the stage.
- Response buffer (data_buf, data_buf_valid), used when WB back-pressures:
  - Set: resp_hit & ms_valid & ms_mem_req & ~ws_allowin captures rdata, data_buf_valid←1.
  - Clear: on handoff (ms_to_ws_valid & ws_allowin) or on except_flush.
- Load data source: data_buf_valid ? data_buf : data_sram_rdata.
- Load extension by ms_result[1:0]:
  - ld_b/ld_bu: byte at lane addr[1:0], sign- or zero-extended.
  - ld_h/ld_hu: half at addr[1] (lanes 1:0 or 3:2), sign- or zero-extended.
  - ld_w: whole word.
  - Non-load: ms_final_result = ms_result.
- Discard flag (one outstanding request max, responses return in order):
  - Set: except_flush while ms_valid & ms_mem_req & ~data_buf_valid & ~data_sram_data_ok.
  - Clear: on the next data_sram_data_ok, which is consumed and dropped.
  - If except_flush coincides with data_ok, there is nothing to discard.
  - After a flush, a new instruction may enter with its own request while discard=1. It stalls until the stale response is dropped, then completes on the following data_ok.
- Exception instructions: es_mem_req=0, so they never wait.
- Flush precedence: except_flush beats simultaneous capture, buffering and handoff. Nothing is latched in that cycle.
- Asynchronous reset mid-transaction clears the discard flag. No response tracking survives reset.

Test Plan:
- ALU op, es_result=0x1234_5678, es_rf_we=1, waddr=5, ws_allowin=1 → ms_to_ws_valid the cycle after capture; ms_final_result=0x12345678; ms_rf_collect[37]=1.
- ld_b at addr 0x...3, data_ok with rdata=0x80FF_0011 in the first MEM cycle → final 0xFFFF_FF80; ld_bu → 0x0000_0080; ld_h at addr 0x...2 → 0xFFFF_80FF; ld_hu → 0x0000_80FF.
- Load; data_ok arrives 3 cycles later → ms_allowin=0 and stall bit in ms_rf_collect=1 until then; single handoff with correct data.
- Load, data_ok while ws_allowin=0 for 2 cycles → data_buf captured; data_sram_rdata changed afterwards; WB receives the originally returned word.
- Outstanding load, except_flush; next instruction, a load, enters with request; two data_ok beats (0xAAAA_AAAA then 0x5555_5555) → first dropped; instruction completes with 0x5555_5555.
- Instruction with es_except=7'b0010000 → ms_ex=1 while valid; no wait for data_ok; except_flush same cycle as new capture → ms_valid=0 next cycle.
